// File: rtl/branch_resolver_pkg.sv
// Shared definitions for the branch resolver: op encodings, FSM state
// constants and small op-classification helpers.
package branch_pkg;

    localparam int unsigned BR_OP_W = 3;

    // Branch op encodings as delivered by decode
    localparam logic [BR_OP_W-1:0] BR_BEQ  = 3'b000;
    localparam logic [BR_OP_W-1:0] BR_BNE  = 3'b001;
    localparam logic [BR_OP_W-1:0] BR_BLEZ = 3'b010;
    localparam logic [BR_OP_W-1:0] BR_BGTZ = 3'b011;
    localparam logic [BR_OP_W-1:0] BR_BLTZ = 3'b100;
    localparam logic [BR_OP_W-1:0] BR_BGEZ = 3'b101;

    // Resolver FSM states
    localparam int unsigned ST_W = 2;
    localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
    localparam logic [ST_W-1:0] ST_REQ  = 2'd1;
    localparam logic [ST_W-1:0] ST_WAIT = 2'd2;
    localparam logic [ST_W-1:0] ST_DONE = 2'd3;

    // Encodings 110/111 are reserved
    function automatic logic br_op_legal(input logic [BR_OP_W-1:0] op);
        return (op <= BR_BGEZ);
    endfunction

    // Only BEQ/BNE compare against rt; the rest compare rs against zero
    function automatic logic br_op_binary(input logic [BR_OP_W-1:0] op);
        return (op == BR_BEQ) || (op == BR_BNE);
    endfunction

endpackage

// File: rtl/branch_resolver_if.sv
// Decode / ALU-arbiter / fetch signal bundle for the branch resolver.
// slave: the resolver itself; master: the surrounding datapath.
interface branch_resolver_if #(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned PC_WIDTH  = 32
) ();

    // Decode request
    logic                          br_valid;
    logic                          br_ready;
    logic [branch_pkg::BR_OP_W-1:0] br_op;
    logic [BUS_WIDTH-1:0]          br_rs;
    logic [BUS_WIDTH-1:0]          br_rt;
    logic [PC_WIDTH-1:0]           br_pc;
    logic [15:0]                   br_offset;

    // Shared ALU port
    logic                          alu_req;
    logic                          alu_gnt;
    logic [BUS_WIDTH-1:0]          alu_a;
    logic [BUS_WIDTH-1:0]          alu_b;
    logic [BUS_WIDTH-1:0]          alu_result;

    // Decision to fetch
    logic                          res_valid;
    logic                          res_ready;
    logic                          res_taken;
    logic [PC_WIDTH-1:0]           res_target;
    logic                          res_illegal;

    modport slave (
        input  br_valid, br_op, br_rs, br_rt, br_pc, br_offset,
        input  alu_gnt, alu_result,
        input  res_ready,
        output br_ready,
        output alu_req, alu_a, alu_b,
        output res_valid, res_taken, res_target, res_illegal
    );

    modport master (
        output br_valid, br_op, br_rs, br_rt, br_pc, br_offset,
        output alu_gnt, alu_result,
        output res_ready,
        input  br_ready,
        input  alu_req, alu_a, alu_b,
        input  res_valid, res_taken, res_target, res_illegal
    );

endinterface

// File: rtl/branch_resolver_flag_eval.sv
// Combinational branch condition evaluation from an rs-minus-x ALU result.
// Kept separate so a future single-cycle branch path can reuse it.
module branch_flag_eval
    import branch_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 32
) (
    input  logic [BUS_WIDTH-1:0] alu_result,
    input  logic [BR_OP_W-1:0]   op,
    output logic                 taken
);

    logic zero;
    logic neg;

    // Derive zero/sign flags and select the condition for the op
    always_comb begin
        zero  = (alu_result == '0);
        neg   = alu_result[BUS_WIDTH-1];
        taken = 1'b0;
        case (op)
            BR_BEQ:  taken = zero;
            BR_BNE:  taken = !zero;
            BR_BLEZ: taken = zero | neg;
            BR_BGTZ: taken = !zero & !neg;
            BR_BLTZ: taken = neg;
            BR_BGEZ: taken = !neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolver.sv
// Multi-cycle branch resolver: accepts one branch from decode, borrows the
// shared ALU for rs - rt (or rs - 0), and returns a registered taken/target
// decision to fetch. All outputs come from flops or the state register.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = 32,
    parameter int unsigned PC_WIDTH  = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_resolver_if.slave bus
);

    logic [ST_W-1:0]      state_q,       state_d;
    logic [BR_OP_W-1:0]   op_q,          op_d;
    logic [PC_WIDTH-1:0]  pc_q,          pc_d;
    logic [PC_WIDTH-1:0]  tgt_q,         tgt_d;
    logic [BUS_WIDTH-1:0] alu_a_q,       alu_a_d;
    logic [BUS_WIDTH-1:0] alu_b_q,       alu_b_d;
    logic                 res_valid_q,   res_valid_d;
    logic                 res_taken_q,   res_taken_d;
    logic [PC_WIDTH-1:0]  res_target_q,  res_target_d;
    logic                 res_illegal_q, res_illegal_d;

    logic [PC_WIDTH-1:0]  offset_ext;
    logic                 flag_taken;

    branch_flag_eval #(
        .BUS_WIDTH (BUS_WIDTH)
    ) u_flag_eval (
        .alu_result (bus.alu_result),
        .op         (op_q),
        .taken      (flag_taken)
    );

    // Next-state, operand capture and decision computation
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        pc_d          = pc_q;
        tgt_d         = tgt_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        res_valid_d   = res_valid_q;
        res_taken_d   = res_taken_q;
        res_target_d  = res_target_q;
        res_illegal_d = res_illegal_q;

        // Word offset, sign-extended and scaled to bytes
        offset_ext = {{(PC_WIDTH-18){bus.br_offset[15]}}, bus.br_offset, 2'b00};

        case (state_q)
            ST_IDLE: begin
                if (bus.br_valid) begin
                    op_d  = bus.br_op;
                    pc_d  = bus.br_pc;
                    tgt_d = bus.br_pc + offset_ext;
                    if (br_op_legal(bus.br_op)) begin
                        alu_a_d       = bus.br_rs;
                        alu_b_d       = br_op_binary(bus.br_op) ? bus.br_rt : '0;
                        res_taken_d   = 1'b0;
                        res_illegal_d = 1'b0;
                        state_d       = ST_REQ;
                    end else begin
                        res_taken_d   = 1'b0;
                        res_illegal_d = 1'b1;
                        res_target_d  = bus.br_pc;
                        state_d       = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                if (bus.alu_gnt) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                res_taken_d  = flag_taken;
                res_target_d = flag_taken ? tgt_q : pc_q;
                state_d      = ST_DONE;
            end
            default: begin
                // res_valid trails entry into DONE by one cycle; the
                // handshake is only honoured once it is visible to fetch
                if (res_valid_q && bus.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    res_valid_d = 1'b1;
                end
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            pc_q          <= '0;
            tgt_q         <= '0;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            res_valid_q   <= 1'b0;
            res_taken_q   <= 1'b0;
            res_target_q  <= '0;
            res_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            pc_q          <= pc_d;
            tgt_q         <= tgt_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            res_valid_q   <= res_valid_d;
            res_taken_q   <= res_taken_d;
            res_target_q  <= res_target_d;
            res_illegal_q <= res_illegal_d;
        end
    end

    // Drive the interface from flops and state decode only
    always_comb begin
        bus.br_ready    = (state_q == ST_IDLE);
        bus.alu_req     = (state_q == ST_REQ);
        bus.alu_a       = alu_a_q;
        bus.alu_b       = alu_b_q;
        bus.res_valid   = res_valid_q;
        bus.res_taken   = res_taken_q;
        bus.res_target  = res_target_q;
        bus.res_illegal = res_illegal_q;
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed cases plus randomized
// transactions compared against a cycle-timeline reference model.
module tb_branch_resolver;
    import branch_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    branch_resolver_if #(.BUS_WIDTH(32), .PC_WIDTH(32)) bus ();

    branch_resolver #(
        .BUS_WIDTH (32),
        .PC_WIDTH  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Architectural branch semantics: signed comparisons of rs against rt or 0
    function automatic logic model_taken(input logic [2:0] op, input logic [31:0] rs,
                                         input logic [31:0] rt);
        int s;
        s = $signed(rs);
        case (op)
            3'd0:    return rs == rt;
            3'd1:    return rs != rt;
            3'd2:    return s <= 0;
            3'd3:    return s > 0;
            3'd4:    return s < 0;
            3'd5:    return s >= 0;
            default: return 1'b0;
        endcase
    endfunction

    // Entered and left at a negedge with the DUT idle.
    // gd: cycles the grant is withheld; rd: cycles res_ready is held low.
    task automatic run_branch(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                              input logic [31:0] pc, input logic [15:0] off,
                              input int unsigned gd, input int unsigned rd);
        logic        legal;
        logic [31:0] b;
        logic [31:0] diff;
        logic [31:0] exp_tgt;
        logic        exp_taken;
        int          off_bytes;
        int unsigned vfirst;
        int unsigned chand;
        logic        in_req;

        legal     = (op <= 3'd5);
        b         = (op == 3'd0 || op == 3'd1) ? rt : 32'd0;
        diff      = rs - b;
        exp_taken = legal && model_taken(op, rs, rt);
        off_bytes = $signed(off) * 4;
        exp_tgt   = exp_taken ? pc + 32'(off_bytes) : pc;
        vfirst    = legal ? 3 + gd : 1;
        chand     = vfirst + rd;

        check_val("br_ready_idle", 64'(bus.br_ready), 64'd1);
        bus.br_valid  = 1'b1;
        bus.br_op     = op;
        bus.br_rs     = rs;
        bus.br_rt     = rt;
        bus.br_pc     = pc;
        bus.br_offset = off;
        bus.alu_gnt   = 1'($urandom);
        bus.res_ready = 1'($urandom);
        @(posedge clk);

        for (int unsigned c = 0; c <= chand; c++) begin
            @(negedge clk);
            in_req = legal && (c <= gd);
            check_val("alu_req", 64'(bus.alu_req), 64'(in_req));
            if (in_req) begin
                check_val("alu_a", 64'(bus.alu_a), 64'(rs));
                check_val("alu_b", 64'(bus.alu_b), 64'(b));
            end
            check_val("br_ready_busy", 64'(bus.br_ready), 64'd0);
            check_val("res_valid", 64'(bus.res_valid), 64'(c >= vfirst));
            if (c >= vfirst) begin
                check_val("res_taken", 64'(bus.res_taken), 64'(exp_taken));
                check_val("res_target", 64'(bus.res_target), 64'(exp_tgt));
                check_val("res_illegal", 64'(bus.res_illegal), 64'(!legal));
            end

            // Busy-time noise that must all be ignored
            bus.br_valid  = 1'($urandom);
            bus.br_op     = 3'($urandom);
            bus.br_rs     = $urandom;
            bus.br_rt     = $urandom;
            bus.br_pc     = $urandom;
            bus.br_offset = 16'($urandom);
            if (legal && c < gd)
                bus.alu_gnt = 1'b0;
            else if (legal && c == gd)
                bus.alu_gnt = 1'b1;
            else
                bus.alu_gnt = 1'($urandom);
            bus.alu_result = (legal && c == gd + 1) ? diff : $urandom;
            bus.res_ready  = (c >= vfirst) ? (c == chand) : 1'($urandom);
        end

        @(negedge clk);
        bus.br_valid = 1'b0;
        check_val("br_ready_back", 64'(bus.br_ready), 64'd1);
        check_val("res_valid_drop", 64'(bus.res_valid), 64'd0);
        check_val("alu_req_idle", 64'(bus.alu_req), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] rs;
        logic [31:0] rt;

        reset          = 1'b1;
        bus.br_valid   = 1'b0;
        bus.br_op      = '0;
        bus.br_rs      = '0;
        bus.br_rt      = '0;
        bus.br_pc      = '0;
        bus.br_offset  = '0;
        bus.alu_gnt    = 1'b0;
        bus.alu_result = '0;
        bus.res_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_br_ready", 64'(bus.br_ready), 64'd1);
        check_val("rst_alu_req", 64'(bus.alu_req), 64'd0);
        check_val("rst_res_valid", 64'(bus.res_valid), 64'd0);
        check_val("rst_res_taken", 64'(bus.res_taken), 64'd0);
        check_val("rst_res_illegal", 64'(bus.res_illegal), 64'd0);
        check_val("rst_res_target", 64'(bus.res_target), 64'd0);
        check_val("rst_alu_a", 64'(bus.alu_a), 64'd0);
        check_val("rst_alu_b", 64'(bus.alu_b), 64'd0);
        reset = 1'b0;

        // Directed cases
        run_branch(3'd0, 32'd5, 32'd5, 32'h100, 16'd4, 0, 0);
        run_branch(3'd3, 32'h8000_0000, 32'h0, 32'h200, 16'd8, 0, 0);
        run_branch(3'd3, 32'd1, 32'h0, 32'h200, 16'd8, 0, 0);
        run_branch(3'd2, 32'd0, 32'h1234, 32'h300, 16'hFFFF, 0, 0);
        run_branch(3'd5, 32'd0, 32'h1, 32'h400, 16'd1, 0, 0);
        run_branch(3'd4, 32'hFFFF_FFFF, 32'h0, 32'h500, 16'd2, 0, 0);
        run_branch(3'd1, 32'd3, 32'd7, 32'h600, 16'd3, 4, 0);
        run_branch(3'd7, 32'd1, 32'd1, 32'h700, 16'd5, 0, 0);
        run_branch(3'd6, 32'd0, 32'd0, 32'h720, 16'd5, 2, 1);
        run_branch(3'd0, 32'd9, 32'd9, 32'h10, 16'h8000, 0, 5);

        // Reset while the ALU result is in flight
        bus.br_valid  = 1'b1;
        bus.br_op     = 3'd0;
        bus.br_rs     = 32'd4;
        bus.br_rt     = 32'd4;
        bus.br_pc     = 32'h800;
        bus.br_offset = 16'd4;
        @(posedge clk);
        @(negedge clk);
        bus.br_valid = 1'b0;
        bus.alu_gnt  = 1'b1;
        @(negedge clk);
        bus.alu_gnt    = 1'b0;
        bus.alu_result = 32'd0;
        bus.res_ready  = 1'b1;
        reset          = 1'b1;
        @(negedge clk);
        check_val("midrst_res_valid", 64'(bus.res_valid), 64'd0);
        check_val("midrst_alu_req", 64'(bus.alu_req), 64'd0);
        check_val("midrst_br_ready", 64'(bus.br_ready), 64'd1);
        check_val("midrst_res_taken", 64'(bus.res_taken), 64'd0);
        check_val("midrst_res_target", 64'(bus.res_target), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("postrst_res_valid", 64'(bus.res_valid), 64'd0);
        check_val("postrst_br_ready", 64'(bus.br_ready), 64'd1);
        run_branch(3'd0, 32'd11, 32'd11, 32'h900, 16'd16, 1, 0);

        // Randomized back-to-back traffic
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 9) == 0)
                op = 3'(6 + $urandom_range(0, 1));
            else
                op = 3'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0:       rs = 32'($signed($urandom_range(0, 8)) - 4);
                1:       rs = $urandom;
                2:       rs = 32'd0;
                default: rs = $urandom_range(0, 1) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            endcase
            rt = $urandom_range(0, 1) ? rs : $urandom;
            run_branch(op, rs, rt, $urandom, 16'($urandom),
                       $urandom_range(0, 3), $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Multi-cycle branch-resolution controller for the processor datapath. Accepts one conditional-branch request at a time from decode and borrows the shared ALU through a request/grant port to compute `rs - rt` (or `rs - 0`). It derives zero and sign flags from the ALU result and returns a registered taken/not-taken decision and the next-PC target to the fetch stage. It sits between decode, the ALU arbiter and PC-select logic.

## Interface
- `BUS_WIDTH`, 32, operand and ALU result width
- `PC_WIDTH`, 32, program-counter width
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `br_valid` in 1: branch request valid
- `br_ready` out 1: block can accept a request (high only in IDLE)
- `br_op` in 3: 000 BEQ, 001 BNE, 010 BLEZ, 011 BGTZ, 100 BLTZ, 101 BGEZ; 110/111 illegal
- `br_rs`, `br_rt` in BUS_WIDTH: operands (`br_rt` ignored for unary ops 010–101)
- `br_pc` in PC_WIDTH: PC+4 of the branch
- `br_offset` in 16: signed word offset
- `alu_req` out 1: ALU requested
- `alu_gnt` in 1: single-cycle grant from the ALU arbiter
- `alu_a`, `alu_b` out BUS_WIDTH: ALU operands; ALU performs `alu_a - alu_b`
- `alu_result` in BUS_WIDTH: ALU output, valid in the cycle after the grant cycle
- `res_valid` out 1: decision valid
- `res_ready` in 1: fetch consumes the decision
- `res_taken` out 1: branch taken
- `res_target` out PC_WIDTH: next PC
- `res_illegal` out 1: `br_op` was illegal

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: `br_ready`=1. On `br_valid`, latch op, operands, PC and target. Target is `br_pc + (sext(br_offset) << 2)`, truncated to PC_WIDTH, wrap-around allowed.
  - Legal op: go to REQ.
  - Illegal op: go to DONE with `res_taken`=0, `res_illegal`=1, `res_target`=`br_pc`.
- REQ: `alu_req`=1, `alu_a`=rs, `alu_b`=rt for BEQ/BNE, otherwise 0. Operands stay stable while `alu_req` is high. Hold REQ until `alu_gnt`=1, then go to WAIT.
- WAIT: one cycle. Evaluate flags from `alu_result`. Register `res_taken`; register `res_target` as the latched target if taken, else `br_pc`. Go to DONE.
- DONE: `res_valid`=1, with outputs held stable until `res_valid && res_ready`; then go to IDLE.
- Flags:
  - zero = (`alu_result` == 0)
  - neg = `alu_result[BUS_WIDTH-1]`
- Conditions:
  - BEQ: zero
  - BNE: !zero
  - BLEZ: zero|neg
  - BGTZ: !zero&!neg
  - BLTZ: neg
  - BGEZ: !neg
- Subtraction overflow is ignored: BEQ/BNE use zero only, and unary ops subtract 0, so sign is exact.
- `alu_gnt` outside REQ is ignored.
- `br_valid` outside IDLE is not accepted (`br_ready`=0).

## Timing
- Reset: state IDLE; `alu_req`, `res_valid`, `res_taken`, `res_illegal` = 0; `res_target`, `alu_a`, `alu_b` = 0. `br_ready`=1 from the first cycle after reset.
- Reset mid-operation: return to IDLE next edge. `alu_req` drops immediately and any in-flight result is discarded. The arbiter must tolerate the withdrawn request.
- Latency, legal op with immediate grant: accept at edge E0; REQ in cycle E0–E1 (grant); WAIT E1–E2; `res_valid` high from E3. Each stalled grant cycle adds one.
- Latency, illegal op: `res_valid` high one cycle after accept.
- Throughput: with `res_ready` tied high, the next accept is possible one cycle after DONE (back in IDLE); no overlap.
- All outputs are registered or decoded from state only; no combinational input-to-output path.

## Structure
- Package `branch_pkg`: `BR_OP_W`=3, op encodings (`BR_BEQ`..`BR_BGEZ`), state enumeration.
- Sub-module `branch_flag_eval`: combinational zero/neg flags plus condition select from (`alu_result`, op) to taken. It is reused by any future single-cycle branch path.
- Top contains the FSM, operand/target registers and output registers.

## Test plan
- BEQ rs=5, rt=5, `br_pc`=0x100, offset=4, `alu_gnt` tied high -> `res_valid` 3 cycles after accept, taken=1, target=0x110.
- BGTZ rs=0x80000000 -> taken=0, target=`br_pc`. BGTZ rs=1 -> taken=1. BLEZ rs=0 -> taken=1. BGEZ rs=0 -> taken=1. BLTZ rs=0xFFFFFFFF -> taken=1.
- BNE rs=3, rt=7, grant withheld 4 cycles -> `alu_req` and operands stable throughout, `res_valid` delayed by 4, taken=1.
- `br_op`=111 -> `alu_req` never asserts, `res_valid` 1 cycle after accept, `res_illegal`=1, taken=0.
- `res_ready` low 5 cycles in DONE -> outputs stable, `br_ready`=0, second `br_valid` not accepted. Offset=0x8000 with `br_pc`=0x10 -> target wraps to 0xFFFE0010.
- `reset` asserted in WAIT -> next cycle IDLE, `res_valid`=0, `alu_req`=0, `br_ready`=1; following BEQ resolves correctly.
